mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding,
// load/store size codes and the default I/O region tag.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // addr[17:16] value that marks the memory-mapped I/O region
    localparam logic [1:0] IO_HI_BITS_DEFAULT = 2'b11;

    // Number of bytes moved for a load/store size code (reserved code 11 moves a word)
    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_to_len = 3'd1;
            SIZE_HALF: size_to_len = 3'd2;
            default:   size_to_len = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-serial RAM arbiter between the instruction fetch path and the
// load/store unit. One transfer at a time, LSB has priority in IDLE.
// Optional macro IO_STALL_EN: stores into the I/O region wait while the
// I/O write buffer reports full.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [1:0] IO_HI_BITS = IO_HI_BITS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic        ic_valid,
    output logic [31:0] ic_data,
    input  logic        lsb_req,
    input  logic        lsb_we,
    input  logic [31:0] lsb_addr,
    input  logic [1:0]  lsb_size,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_valid,
    output logic [31:0] lsb_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [2:0]  len_q;
    logic        src_lsb_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf_q;
    logic [31:0] mem_a_q;
    logic [7:0]  mem_dout_q;
    logic        mem_wr_q;
    logic        ic_valid_q;
    logic        lsb_valid_q;
    logic [31:0] ic_data_q;
    logic [31:0] lsb_rdata_q;
    logic        rdy_q;
    logic [7:0]  din_hold_q;

    logic [7:0]  din_d;
    logic [1:0]  lane_cap_d;
    logic [1:0]  lane_nxt_d;
    logic [31:0] rword_d;
    logic [31:0] addr_nxt_d;
    logic        io_region;
    logic        stall;

    // Capture lane / next address, plus the byte to merge into the read buffer.
    // After a freeze the RAM output has moved on, so the byte seen in the first
    // frozen cycle is replayed from din_hold_q.
    always_comb begin
        din_d      = rdy_q ? mem_din : din_hold_q;
        lane_cap_d = 2'(cnt_q - 3'd1);
        lane_nxt_d = 2'(cnt_q + 3'd1);
        rword_d    = rbuf_q;
        rword_d[{lane_cap_d, 3'b000} +: 8] = din_d;
        addr_nxt_d = addr_q + {29'd0, cnt_q} + 32'd1;
    end

    assign io_region = (state_q == S_WRITE) && (addr_q[17:16] == IO_HI_BITS);
`ifdef IO_STALL_EN
    assign stall = io_region && io_buffer_full;
`else
    // Buffer-full flag is observed but never holds a write in this build
    assign stall = io_region && io_buffer_full && 1'b0;
`endif

    // Transfer FSM with registered RAM-side and requester-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            len_q       <= 3'd0;
            src_lsb_q   <= 1'b0;
            mem_a_q     <= 32'd0;
            mem_dout_q  <= 8'd0;
            mem_wr_q    <= 1'b0;
            ic_valid_q  <= 1'b0;
            lsb_valid_q <= 1'b0;
            ic_data_q   <= 32'd0;
            lsb_rdata_q <= 32'd0;
        end else if (rdy) begin
            case (state_q)
                S_IDLE: begin
                    if (lsb_req || ic_req) begin
                        src_lsb_q <= lsb_req;
                        addr_q    <= lsb_req ? lsb_addr : ic_addr;
                        mem_a_q   <= lsb_req ? lsb_addr : ic_addr;
                        len_q     <= lsb_req ? size_to_len(lsb_size) : 3'd4;
                        wdata_q   <= lsb_wdata;
                        rbuf_q    <= 32'd0;
                        cnt_q     <= 3'd0;
                        if (lsb_req && lsb_we) begin
                            mem_wr_q   <= 1'b1;
                            mem_dout_q <= lsb_wdata[7:0];
                            state_q    <= S_WRITE;
                        end else begin
                            state_q    <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (cnt_q != 3'd0) rbuf_q <= rword_d;
                    if (cnt_q == len_q) begin
                        state_q <= S_DONE;
                        mem_a_q <= 32'd0;
                        if (src_lsb_q) begin
                            lsb_valid_q <= 1'b1;
                            lsb_rdata_q <= rword_d;
                        end else begin
                            ic_valid_q  <= 1'b1;
                            ic_data_q   <= rword_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q + 3'd1 != len_q) mem_a_q <= addr_nxt_d;
                    end
                end
                S_WRITE: begin
                    if (!stall) begin
                        if (cnt_q + 3'd1 == len_q) begin
                            state_q     <= S_DONE;
                            mem_wr_q    <= 1'b0;
                            mem_a_q     <= 32'd0;
                            lsb_valid_q <= 1'b1;
                        end else begin
                            cnt_q      <= cnt_q + 3'd1;
                            mem_a_q    <= addr_nxt_d;
                            mem_dout_q <= wdata_q[{lane_nxt_d, 3'b000} +: 8];
                        end
                    end
                end
                S_DONE: begin
                    ic_valid_q  <= 1'b0;
                    lsb_valid_q <= 1'b0;
                    cnt_q       <= 3'd0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Track freeze edges and keep the RAM byte that arrives as a freeze begins
    always_ff @(posedge clk) begin
        if (rst) rdy_q <= 1'b1;
        else     rdy_q <= rdy;
        if (!rdy && rdy_q) din_hold_q <= mem_din;
    end

    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign mem_wr    = mem_wr_q && rdy && !stall;
    assign ic_valid  = ic_valid_q;
    assign ic_data   = ic_data_q;
    assign lsb_valid = lsb_valid_q;
    assign lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small byte RAM model.
// Define IO_STALL_EN for both bench and RTL to exercise the I/O stall path.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        ic_req, lsb_req, lsb_we, io_buffer_full;
    logic [31:0] ic_addr, lsb_addr, lsb_wdata;
    logic [1:0]  lsb_size;
    logic        ic_valid, lsb_valid, mem_wr;
    logic [31:0] ic_data, lsb_rdata, mem_a;
    logic [7:0]  mem_din, mem_dout;

    logic        ld_en;
    logic [11:0] ld_addr;
    logic [7:0]  ld_data;
    logic [7:0]  ram [0:4095];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_valid(ic_valid), .ic_data(ic_data),
        .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_addr(lsb_addr), .lsb_size(lsb_size),
        .lsb_wdata(lsb_wdata), .lsb_valid(lsb_valid), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    // Free-running synchronous RAM: read data one cycle after the address
    always @(posedge clk) begin
        mem_din <= ram[mem_a[11:0]];
        if (ld_en)       ram[ld_addr] <= ld_data;
        else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; ic_req = 0; lsb_req = 0; lsb_we = 0;
        ic_addr = 0; lsb_addr = 0; lsb_size = 0; lsb_wdata = 0; io_buffer_full = 0;
        ld_en = 0; ld_addr = 0; ld_data = 0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        tick();
        poke(12'h100, 8'h13); poke(12'h101, 8'h05); poke(12'h102, 8'h00); poke(12'h103, 8'h00);
        poke(12'h200, 8'hA5);
        poke(12'h104, 8'h11); poke(12'h105, 8'h22); poke(12'h106, 8'h33); poke(12'h107, 8'h44);
        poke(12'hFFE, 8'h01); poke(12'hFFF, 8'h02); poke(12'h000, 8'h03); poke(12'h001, 8'h04);
        #1;
        checks++; if (mem_a !== 32'd0)     begin errors++; $display("FAIL reset_mem_a got %h want 0", mem_a); end
        checks++; if (mem_wr !== 1'b0)     begin errors++; $display("FAIL reset_mem_wr got %b want 0", mem_wr); end
        checks++; if (mem_dout !== 8'd0)   begin errors++; $display("FAIL reset_mem_dout got %h want 0", mem_dout); end
        checks++; if (ic_valid !== 1'b0)   begin errors++; $display("FAIL reset_ic_valid got %b want 0", ic_valid); end
        checks++; if (lsb_valid !== 1'b0)  begin errors++; $display("FAIL reset_lsb_valid got %b want 0", lsb_valid); end
        checks++; if (ic_data !== 32'd0)   begin errors++; $display("FAIL reset_ic_data got %h want 0", ic_data); end
        checks++; if (lsb_rdata !== 32'd0) begin errors++; $display("FAIL reset_lsb_rdata got %h want 0", lsb_rdata); end
        tick();
        rst = 1'b0;
        tick();
        #1;
        checks++; if (mem_a !== 32'd0) begin errors++; $display("FAIL idle_mem_a got %h want 0", mem_a); end
    endtask

    task automatic test_fetch();
        for (int c = 0; c <= 7; c++) begin
            tick();
            if (c == 0) begin ic_req = 1'b1; ic_addr = 32'h100; end
            if (c == 6) ic_req = 1'b0;
            #1;
            if (c == 0) begin
                checks++; if (mem_a !== 32'd0) begin errors++; $display("FAIL fetch_c0_mem_a got %h want 0", mem_a); end
            end
            if (c >= 1 && c <= 4) begin
                checks++; if (mem_a !== 32'(32'h100 + c - 1)) begin errors++; $display("FAIL fetch_mem_a c%0d got %h want %h", c, mem_a, 32'h100 + c - 1); end
                checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL fetch_mem_wr c%0d got %b want 0", c, mem_wr); end
            end
            if (c == 6) begin
                checks++; if (ic_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid got %b want 1", ic_valid); end
                checks++; if (ic_data !== 32'h00000513) begin errors++; $display("FAIL fetch_data got %h want 00000513", ic_data); end
            end else begin
                checks++; if (ic_valid !== 1'b0) begin errors++; $display("FAIL fetch_valid_low c%0d got %b want 0", c, ic_valid); end
            end
        end
    endtask

    task automatic test_tie();
        for (int c = 0; c <= 11; c++) begin
            tick();
            if (c == 0) begin
                ic_req = 1'b1; ic_addr = 32'h104;
                lsb_req = 1'b1; lsb_we = 1'b0; lsb_size = 2'b00; lsb_addr = 32'h200;
            end
            if (c == 3) lsb_req = 1'b0;
            if (c == 10) ic_req = 1'b0;
            #1;
            if (c == 1) begin
                checks++; if (mem_a !== 32'h200) begin errors++; $display("FAIL tie_load_addr got %h want 00000200", mem_a); end
            end
            if (c == 2) begin
                checks++; if (lsb_valid !== 1'b0) begin errors++; $display("FAIL tie_early_valid got %b want 0", lsb_valid); end
            end
            if (c == 3) begin
                checks++; if (lsb_valid !== 1'b1) begin errors++; $display("FAIL tie_lsb_valid got %b want 1", lsb_valid); end
                checks++; if (lsb_rdata !== 32'h000000A5) begin errors++; $display("FAIL tie_lsb_rdata got %h want 000000a5", lsb_rdata); end
            end
            if (c == 4) begin
                checks++; if (mem_a !== 32'd0) begin errors++; $display("FAIL tie_idle_mem_a got %h want 0", mem_a); end
            end
            if (c == 5) begin
                checks++; if (mem_a !== 32'h104) begin errors++; $display("FAIL tie_fetch_start got %h want 00000104", mem_a); end
            end
            if (c == 10) begin
                checks++; if (ic_valid !== 1'b1) begin errors++; $display("FAIL tie_ic_valid got %b want 1", ic_valid); end
                checks++; if (ic_data !== 32'h44332211) begin errors++; $display("FAIL tie_ic_data got %h want 44332211", ic_data); end
                checks++; if (lsb_rdata !== 32'h000000A5) begin errors++; $display("FAIL tie_rdata_hold got %h want 000000a5", lsb_rdata); end
            end else begin
                checks++; if (ic_valid !== 1'b0) begin errors++; $display("FAIL tie_ic_valid_low c%0d got %b want 0", c, ic_valid); end
            end
        end
    endtask

    task automatic test_store();
        for (int c = 0; c <= 4; c++) begin
            tick();
            if (c == 0) begin
                lsb_req = 1'b1; lsb_we = 1'b1; lsb_size = 2'b01; lsb_addr = 32'h10; lsb_wdata = 32'hABCD1234;
            end
            if (c == 3) begin lsb_req = 1'b0; lsb_we = 1'b0; end
            #1;
            if (c == 1) begin
                checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h10 || mem_dout !== 8'h34) begin errors++; $display("FAIL store_b0 got wr=%b a=%h d=%h want wr=1 a=00000010 d=34", mem_wr, mem_a, mem_dout); end
            end
            if (c == 2) begin
                checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h11 || mem_dout !== 8'h12) begin errors++; $display("FAIL store_b1 got wr=%b a=%h d=%h want wr=1 a=00000011 d=12", mem_wr, mem_a, mem_dout); end
            end
            if (c == 3) begin
                checks++; if (lsb_valid !== 1'b1 || mem_wr !== 1'b0) begin errors++; $display("FAIL store_done got valid=%b wr=%b want valid=1 wr=0", lsb_valid, mem_wr); end
            end
            if (c == 0 || c == 4) begin
                checks++; if (mem_wr !== 1'b0 || lsb_valid !== 1'b0) begin errors++; $display("FAIL store_quiet c%0d got wr=%b valid=%b want 0 0", c, mem_wr, lsb_valid); end
            end
        end
    endtask

    task automatic test_load_wrap();
        for (int c = 0; c <= 6; c++) begin
            tick();
            if (c == 0) begin
                lsb_req = 1'b1; lsb_we = 1'b0; lsb_size = 2'b10; lsb_addr = 32'hFFFFFFFE;
            end
            if (c == 6) lsb_req = 1'b0;
            #1;
            if (c >= 1 && c <= 4) begin
                checks++; if (mem_a !== 32'(32'hFFFFFFFE + c - 1)) begin errors++; $display("FAIL wrap_mem_a c%0d got %h want %h", c, mem_a, 32'(32'hFFFFFFFE + c - 1)); end
            end
            if (c == 5) begin
                checks++; if (lsb_valid !== 1'b0) begin errors++; $display("FAIL wrap_early_valid got %b want 0", lsb_valid); end
            end
            if (c == 6) begin
                checks++; if (lsb_valid !== 1'b1 || lsb_rdata !== 32'h04030201) begin errors++; $display("FAIL wrap_word got valid=%b data=%h want 1 04030201", lsb_valid, lsb_rdata); end
            end
        end
        // Half load of the stored bytes: checks zero extension and the store landing in RAM
        for (int c = 0; c <= 4; c++) begin
            tick();
            if (c == 0) begin
                lsb_req = 1'b1; lsb_we = 1'b0; lsb_size = 2'b01; lsb_addr = 32'h10;
            end
            if (c == 4) lsb_req = 1'b0;
            #1;
            if (c == 3) begin
                checks++; if (lsb_valid !== 1'b0) begin errors++; $display("FAIL half_early_valid got %b want 0", lsb_valid); end
            end
            if (c == 4) begin
                checks++; if (lsb_valid !== 1'b1 || lsb_rdata !== 32'h00001234) begin errors++; $display("FAIL half_load got valid=%b data=%h want 1 00001234", lsb_valid, lsb_rdata); end
            end
        end
    endtask

    task automatic test_freeze();
        for (int c = 0; c <= 9; c++) begin
            tick();
            if (c == 0) begin ic_req = 1'b1; ic_addr = 32'h100; end
            if (c == 3) rdy = 1'b0;
            if (c == 5) rdy = 1'b1;
            if (c == 8) ic_req = 1'b0;
            #1;
            if (c >= 3 && c <= 5) begin
                checks++; if (mem_a !== 32'h102) begin errors++; $display("FAIL freeze_hold_addr c%0d got %h want 00000102", c, mem_a); end
            end
            if (c == 6) begin
                checks++; if (mem_a !== 32'h103) begin errors++; $display("FAIL freeze_resume_addr got %h want 00000103", mem_a); end
            end
            if (c == 8) begin
                checks++; if (ic_valid !== 1'b1 || ic_data !== 32'h00000513) begin errors++; $display("FAIL freeze_fetch got valid=%b data=%h want 1 00000513", ic_valid, ic_data); end
            end else begin
                checks++; if (ic_valid !== 1'b0) begin errors++; $display("FAIL freeze_valid_low c%0d got %b want 0", c, ic_valid); end
            end
        end
        for (int c = 0; c <= 3; c++) begin
            tick();
            if (c == 0) begin
                lsb_req = 1'b1; lsb_we = 1'b1; lsb_size = 2'b00; lsb_addr = 32'h20; lsb_wdata = 32'h0000005A;
            end
            if (c == 1) rdy = 1'b0;
            if (c == 2) rdy = 1'b1;
            if (c == 3) begin lsb_req = 1'b0; lsb_we = 1'b0; end
            #1;
            if (c == 1) begin
                checks++; if (mem_wr !== 1'b0 || mem_a !== 32'h20) begin errors++; $display("FAIL freeze_store_wr got wr=%b a=%h want 0 00000020", mem_wr, mem_a); end
            end
            if (c == 2) begin
                checks++; if (mem_wr !== 1'b1 || mem_dout !== 8'h5A || lsb_valid !== 1'b0) begin errors++; $display("FAIL freeze_store_resume got wr=%b d=%h v=%b want 1 5a 0", mem_wr, mem_dout, lsb_valid); end
            end
            if (c == 3) begin
                checks++; if (lsb_valid !== 1'b1 || mem_wr !== 1'b0) begin errors++; $display("FAIL freeze_store_done got v=%b wr=%b want 1 0", lsb_valid, mem_wr); end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c <= 10; c++) begin
            tick();
            if (c == 0) begin ic_req = 1'b1; ic_addr = 32'h100; end
            if (c == 2) rst = 1'b1;
            if (c == 3) rst = 1'b0;
            if (c == 9) ic_req = 1'b0;
            #1;
            if (c == 3) begin
                checks++; if (mem_a !== 32'd0 || mem_wr !== 1'b0 || ic_valid !== 1'b0) begin errors++; $display("FAIL rstmid_idle got a=%h wr=%b v=%b want 0 0 0", mem_a, mem_wr, ic_valid); end
                checks++; if (ic_data !== 32'd0) begin errors++; $display("FAIL rstmid_data_clear got %h want 0", ic_data); end
            end
            if (c == 4) begin
                checks++; if (mem_a !== 32'h100) begin errors++; $display("FAIL rstmid_restart got %h want 00000100", mem_a); end
            end
            if (c == 8) begin
                checks++; if (ic_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early_valid got %b want 0", ic_valid); end
            end
            if (c == 9) begin
                checks++; if (ic_valid !== 1'b1 || ic_data !== 32'h00000513) begin errors++; $display("FAIL rstmid_fetch got valid=%b data=%h want 1 00000513", ic_valid, ic_data); end
            end
        end
    endtask

    task automatic test_io();
`ifdef IO_STALL_EN
        for (int c = 0; c <= 6; c++) begin
            tick();
            if (c == 0) begin
                lsb_req = 1'b1; lsb_we = 1'b1; lsb_size = 2'b00; lsb_addr = 32'h00030000;
                lsb_wdata = 32'h00000041; io_buffer_full = 1'b1;
            end
            if (c == 4) io_buffer_full = 1'b0;
            if (c == 5) begin lsb_req = 1'b0; lsb_we = 1'b0; end
            #1;
            if (c >= 1 && c <= 3) begin
                checks++; if (mem_wr !== 1'b0 || mem_a !== 32'h00030000 || lsb_valid !== 1'b0) begin errors++; $display("FAIL io_stall c%0d got wr=%b a=%h v=%b want 0 00030000 0", c, mem_wr, mem_a, lsb_valid); end
            end
            if (c == 4) begin
                checks++; if (mem_wr !== 1'b1 || mem_dout !== 8'h41 || lsb_valid !== 1'b0) begin errors++; $display("FAIL io_release got wr=%b d=%h v=%b want 1 41 0", mem_wr, mem_dout, lsb_valid); end
            end
            if (c == 5) begin
                checks++; if (lsb_valid !== 1'b1 || mem_wr !== 1'b0) begin errors++; $display("FAIL io_done got v=%b wr=%b want 1 0", lsb_valid, mem_wr); end
            end
        end
`else
        for (int c = 0; c <= 3; c++) begin
            tick();
            if (c == 0) begin
                lsb_req = 1'b1; lsb_we = 1'b1; lsb_size = 2'b00; lsb_addr = 32'h00030000;
                lsb_wdata = 32'h00000041; io_buffer_full = 1'b1;
            end
            if (c == 2) begin lsb_req = 1'b0; lsb_we = 1'b0; end
            #1;
            if (c == 1) begin
                checks++; if (mem_wr !== 1'b1 || mem_dout !== 8'h41 || mem_a !== 32'h00030000) begin errors++; $display("FAIL io_ignored got wr=%b d=%h a=%h want 1 41 00030000", mem_wr, mem_dout, mem_a); end
            end
            if (c == 2) begin
                checks++; if (lsb_valid !== 1'b1 || mem_wr !== 1'b0) begin errors++; $display("FAIL io_done got v=%b wr=%b want 1 0", lsb_valid, mem_wr); end
            end
        end
        io_buffer_full = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_tie();
        test_store();
        test_load_wrap();
        test_freeze();
        test_reset_mid();
        test_io();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
